// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared types and digit limits for the time-of-day chain.
//                Holds the set-mode enum, per-digit wrap limits, hour-range
//                limits for both the 24 h and 12 h builds, and small BCD
//                helpers used by the hours pair logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Set-mode FSM states; encoding is also the externally visible mode code.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_e;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] SEC_HI_MAX = 4'd5;
    localparam logic [3:0] MIN_HI_MAX = 4'd5;

    localparam int HR24_MAX = 23;
    localparam int HR12_MIN = 1;
    localparam int HR12_MAX = 12;

    // Decimal value of a two-digit BCD pair.
    function automatic int bcd_pair_value(input logic [3:0] hi, input logic [3:0] lo);
        return (int'(hi) * 10) + int'(lo);
    endfunction

    // Tens and ones BCD digits of a small non-negative integer.
    function automatic logic [3:0] bcd_tens(input int v);
        return 4'(v / 10);
    endfunction

    function automatic logic [3:0] bcd_ones(input int v);
        return 4'(v % 10);
    endfunction

endpackage : clock_pkg
`default_nettype wire

// File: rtl/time_keeper_ctrl_bcd_digit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_counter
//  Description : One BCD digit that counts 0..i_max when enabled and wraps
//                to 0. o_carry_out is high in the cycle the digit wraps, so
//                chained digits all settle on the same clock edge.
//  Ports       : clk          - system clock
//                reset        - asynchronous active-high reset (digit -> 0)
//                i_en         - count enable for this cycle
//                i_max        - last value before wrap
//                i_clear      - synchronous clear, overrides i_en
//                o_q          - registered digit value
//                o_carry_out  - combinational wrap indication
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic [3:0] i_max,
    input  logic       i_clear,
    output logic [3:0] o_q,
    output logic       o_carry_out
);

    logic [3:0] r_q;
    logic       w_at_max;

    assign w_at_max = (r_q == i_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 4'd0;
        end else if (i_clear) begin
            r_q <= 4'd0;
        end else if (i_en) begin
            r_q <= w_at_max ? 4'd0 : (r_q + 4'd1);
        end
    end

    assign o_q         = r_q;
    // A cleared digit never propagates a carry.
    assign o_carry_out = i_en && w_at_max && !i_clear;

endmodule : bcd_digit_counter
`default_nettype wire

// File: rtl/time_keeper_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : time_keeper_ctrl
//  Description : Time-of-day controller. Divides clk into a one-second tick,
//                ripples carries through the six BCD digits in one edge, and
//                runs a RUN -> SET_HR -> SET_MIN set-mode FSM from two
//                pre-debounced button pulses. Field blink is generated while
//                setting.
//  Build macro : TWELVE_HOUR_EN - hours run 01..12 with a PM indicator;
//                undefined gives 00..23 hours and pm tied low.
//  Ports       : clk, reset           - clock, async active-high reset
//                mode_btn, adv_btn    - single-cycle button pulses
//                sec_lo .. hr_hi      - registered BCD digits
//                mode                 - 0 RUN, 1 SET_HR, 2 SET_MIN
//                blink                - field-blink enable
//                pm                   - PM indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module time_keeper_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       adv_btn,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic [1:0] mode,
    output logic       blink,
    output logic       pm
);

    import clock_pkg::*;

    localparam int c_PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

`ifdef TWELVE_HOUR_EN
    localparam logic [3:0] c_HR_HI_RST = bcd_tens(HR12_MAX);
    localparam logic [3:0] c_HR_LO_RST = bcd_ones(HR12_MAX);
`else
    localparam logic [3:0] c_HR_HI_RST = 4'd0;
    localparam logic [3:0] c_HR_LO_RST = 4'd0;
`endif

    // ------------------------------------------------------------------
    // Set-mode FSM
    // ------------------------------------------------------------------
    mode_e r_state;
    mode_e w_state_nxt;
    logic  w_tick;
    logic  w_sec_clr;
    logic  w_min_adv;
    logic  w_hr_adv;
    logic  w_set_entry;

    logic [c_PRESC_W-1:0] r_presc;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        w_sec_clr   = 1'b0;
        w_min_adv   = 1'b0;
        w_hr_adv    = 1'b0;
        w_set_entry = 1'b0;
        case (r_state)
            RUN: begin
                // adv_btn is deliberately ignored while running.
                w_tick = (r_presc == c_PRESC_LAST);
                if (mode_btn) begin
                    w_state_nxt = SET_HR;
                    w_set_entry = 1'b1;
                end
            end
            SET_HR: begin
                w_hr_adv = adv_btn;
                if (mode_btn) begin
                    w_state_nxt = SET_MIN;
                    w_set_entry = 1'b1;
                end
            end
            SET_MIN: begin
                w_min_adv = adv_btn;
                if (mode_btn) begin
                    w_state_nxt = RUN;
                    w_sec_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-second prescaler: free-runs only in RUN, so a fresh second
    // starts every time the clock resumes after setting.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if ((r_state != RUN) || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Blink: restarts high with a fresh half-period on each set-state
    // entry, forced low whenever the next state is RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_set_entry) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (w_state_nxt == RUN) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
            r_blink     <= ~r_blink;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Seconds and minutes digit chain
    // ------------------------------------------------------------------
    logic w_sec_lo_co;
    logic w_sec_hi_co;
    logic w_min_lo_co;
    logic w_min_hi_co;

    bcd_digit_counter u_sec_lo (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_tick),
        .i_max       (DIGIT_MAX),
        .i_clear     (w_sec_clr),
        .o_q         (sec_lo),
        .o_carry_out (w_sec_lo_co)
    );

    bcd_digit_counter u_sec_hi (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_sec_lo_co),
        .i_max       (SEC_HI_MAX),
        .i_clear     (w_sec_clr),
        .o_q         (sec_hi),
        .o_carry_out (w_sec_hi_co)
    );

    bcd_digit_counter u_min_lo (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_sec_hi_co | w_min_adv),
        .i_max       (DIGIT_MAX),
        .i_clear     (1'b0),
        .o_q         (min_lo),
        .o_carry_out (w_min_lo_co)
    );

    bcd_digit_counter u_min_hi (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_min_lo_co),
        .i_max       (MIN_HI_MAX),
        .i_clear     (1'b0),
        .o_q         (min_hi),
        .o_carry_out (w_min_hi_co)
    );

    // ------------------------------------------------------------------
    // Hours pair. Minute wrap only carries into hours while running; a
    // minute wrap caused by adv_btn in SET_MIN must not touch the hours.
    // ------------------------------------------------------------------
    logic [3:0] r_hr_hi;
    logic [3:0] r_hr_lo;
    logic [3:0] w_hr_hi_nxt;
    logic [3:0] w_hr_lo_nxt;
    logic       w_hr_en;
    int         w_hr_val;

    assign w_hr_en  = (w_min_hi_co && (r_state == RUN)) || w_hr_adv;
    assign w_hr_val = bcd_pair_value(r_hr_hi, r_hr_lo);

`ifdef TWELVE_HOUR_EN
    logic r_pm;
    logic w_pm_nxt;

    always_comb begin
        w_hr_hi_nxt = r_hr_hi;
        w_hr_lo_nxt = r_hr_lo;
        w_pm_nxt    = r_pm;
        if (w_hr_en) begin
            if (w_hr_val == HR12_MAX) begin
                w_hr_hi_nxt = bcd_tens(HR12_MIN);
                w_hr_lo_nxt = bcd_ones(HR12_MIN);
            end else if (r_hr_lo == DIGIT_MAX) begin
                w_hr_hi_nxt = r_hr_hi + 4'd1;
                w_hr_lo_nxt = 4'd0;
            end else begin
                w_hr_lo_nxt = r_hr_lo + 4'd1;
            end
            // AM/PM flips on the 11 -> 12 step, not on 12 -> 01.
            if (w_hr_val == (HR12_MAX - 1)) begin
                w_pm_nxt = ~r_pm;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pm <= 1'b0;
        end else begin
            r_pm <= w_pm_nxt;
        end
    end

    assign pm = r_pm;
`else
    always_comb begin
        w_hr_hi_nxt = r_hr_hi;
        w_hr_lo_nxt = r_hr_lo;
        if (w_hr_en) begin
            if (w_hr_val == HR24_MAX) begin
                w_hr_hi_nxt = 4'd0;
                w_hr_lo_nxt = 4'd0;
            end else if (r_hr_lo == DIGIT_MAX) begin
                w_hr_hi_nxt = r_hr_hi + 4'd1;
                w_hr_lo_nxt = 4'd0;
            end else begin
                w_hr_lo_nxt = r_hr_lo + 4'd1;
            end
        end
    end

    assign pm = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hr_hi <= c_HR_HI_RST;
            r_hr_lo <= c_HR_LO_RST;
        end else begin
            r_hr_hi <= w_hr_hi_nxt;
            r_hr_lo <= w_hr_lo_nxt;
        end
    end

    assign hr_hi = r_hr_hi;
    assign hr_lo = r_hr_lo;
    assign mode  = r_state;
    assign blink = r_blink;

endmodule : time_keeper_ctrl
`default_nettype wire

// File: tb/tb_time_keeper_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_keeper_ctrl
//  Description : Self-checking bench for time_keeper_ctrl. A table of
//                directed vectors, hand-written 12 h sequences (when
//                TWELVE_HOUR_EN is defined), and random button traffic
//                compared every cycle against a time-of-day reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_keeper_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 3;

`ifdef TWELVE_HOUR_EN
    localparam int c_RST_HR = 12;
`else
    localparam int c_RST_HR = 0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       mode_btn = 1'b0;
    logic       adv_btn  = 1'b0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
    logic [1:0] mode;
    logic       blink;
    logic       pm;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain hours/minutes/seconds numbers.
    int m_hr, m_min, m_sec, m_pm, m_mode, m_run_cyc, m_k;

    time_keeper_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode_btn (mode_btn),
        .adv_btn  (adv_btn),
        .sec_lo   (sec_lo),
        .sec_hi   (sec_hi),
        .min_lo   (min_lo),
        .min_hi   (min_hi),
        .hr_lo    (hr_lo),
        .hr_hi    (hr_hi),
        .mode     (mode),
        .blink    (blink),
        .pm       (pm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_hr = c_RST_HR; m_min = 0; m_sec = 0; m_pm = 0;
        m_mode = 0; m_run_cyc = 0; m_k = 0;
    endtask

    task automatic model_hour_inc();
`ifdef TWELVE_HOUR_EN
        m_hr = (m_hr % 12) + 1;
        if (m_hr == 12) m_pm = 1 - m_pm;
`else
        m_hr = (m_hr + 1) % 24;
`endif
    endtask

    task automatic model_second();
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0;
            m_min++;
            if (m_min == 60) begin
                m_min = 0;
                model_hour_inc();
            end
        end
    endtask

    task automatic model_step(input bit mb, input bit ab);
        case (m_mode)
            0: begin
                m_run_cyc++;
                if ((m_run_cyc % TICK_DIV) == 0) model_second();
                if (mb) begin m_mode = 1; m_k = 0; end
            end
            1: begin
                if (ab) model_hour_inc();
                if (mb) begin m_mode = 2; m_k = 0; end
                else m_k++;
            end
            default: begin
                if (ab) m_min = (m_min + 1) % 60;
                if (mb) begin m_mode = 0; m_sec = 0; m_run_cyc = 0; end
                else m_k++;
            end
        endcase
    endtask

    task automatic check_model();
        int exp_blink;
        exp_blink = (m_mode != 0 && ((m_k / BLINK_DIV) % 2) == 0) ? 1 : 0;
        chk("sec_lo", int'(sec_lo), m_sec % 10);
        chk("sec_hi", int'(sec_hi), m_sec / 10);
        chk("min_lo", int'(min_lo), m_min % 10);
        chk("min_hi", int'(min_hi), m_min / 10);
        chk("hr_lo",  int'(hr_lo),  m_hr % 10);
        chk("hr_hi",  int'(hr_hi),  m_hr / 10);
        chk("mode",   int'(mode),   m_mode);
        chk("blink",  int'(blink),  exp_blink);
        chk("pm",     int'(pm),     m_pm);
    endtask

    task automatic chk_time(input string tag, input int hr, input int mn, input int sc,
                            input int md, input int bl, input int p);
        chk({tag, "_hr"},    int'(hr_hi) * 10 + int'(hr_lo), hr);
        chk({tag, "_min"},   int'(min_hi) * 10 + int'(min_lo), mn);
        chk({tag, "_sec"},   int'(sec_hi) * 10 + int'(sec_lo), sc);
        chk({tag, "_mode"},  int'(mode), md);
        chk({tag, "_blink"}, int'(blink), bl);
        chk({tag, "_pm"},    int'(pm), p);
    endtask

    // One clock: drive buttons, advance model at the edge, compare after it.
    task automatic cyc(input bit mb, input bit ab);
        mode_btn = mb;
        adv_btn  = ab;
        @(posedge clk);
        model_step(mb, ab);
        #1;
        check_model();
    endtask

    task automatic mid_reset();
        mode_btn = 1'b0;
        adv_btn  = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk_time("async_rst", c_RST_HR, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit mb;
        bit ab;
        int n;
        int hr;
        int mn;
        int sc;
        int md;
        int bl;
    } vec_t;

    vec_t vecs[19];
    vec_t v;
    bit   r_mb, r_ab;

    initial begin
        vecs[0]  = '{1'b0, 1'b0,   4,  0,  0,  1, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 236,  0,  1,  0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0,   1,  0,  1,  0, 1, 1};
        vecs[3]  = '{1'b0, 1'b1,   5,  5,  1,  0, 1, 0};
        vecs[4]  = '{1'b1, 1'b0,   1,  5,  1,  0, 2, 1};
        vecs[5]  = '{1'b0, 1'b1,  58,  5, 59,  0, 2, 0};
        vecs[6]  = '{1'b0, 1'b1,   1,  5,  0,  0, 2, 0};
        vecs[7]  = '{1'b1, 1'b0,   1,  5,  0,  0, 0, 0};
        vecs[8]  = '{1'b1, 1'b0,   1,  5,  0,  0, 1, 1};
        vecs[9]  = '{1'b0, 1'b1,  18, 23,  0,  0, 1, 1};
        vecs[10] = '{1'b1, 1'b0,   1, 23,  0,  0, 2, 1};
        vecs[11] = '{1'b0, 1'b1,  59, 23, 59,  0, 2, 0};
        vecs[12] = '{1'b1, 1'b0,   1, 23, 59,  0, 0, 0};
        vecs[13] = '{1'b0, 1'b0, 239, 23, 59, 59, 0, 0};
        vecs[14] = '{1'b0, 1'b0,   1,  0,  0,  0, 0, 0};
        vecs[15] = '{1'b0, 1'b0,  39,  0,  0,  9, 0, 0};
        vecs[16] = '{1'b1, 1'b0,   1,  0,  0, 10, 1, 1};
        vecs[17] = '{1'b1, 1'b1,   1,  1,  0, 10, 2, 1};
        vecs[18] = '{1'b1, 1'b1,   1,  1,  1,  0, 0, 0};

        model_reset();
        #2;
        chk_time("reset", c_RST_HR, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        reset = 1'b0;

`ifndef TWELVE_HOUR_EN
        for (int i = 0; i < 19; i++) begin
            v = vecs[i];
            for (int j = 0; j < v.n; j++) cyc(v.mb, v.ab);
            chk_time($sformatf("vec%0d", i), v.hr, v.mn, v.sc, v.md, v.bl, 0);
        end
`else
        // 12 h: preload 11:59:00 through set mode, then roll into 12 PM.
        cyc(1'b1, 1'b0);
        for (int j = 0; j < 11; j++) cyc(1'b0, 1'b1);
        chk_time("h12_set11", 11, 0, 0, 1, (11 / BLINK_DIV) % 2 == 0 ? 1 : 0, 0);
        cyc(1'b1, 1'b0);
        for (int j = 0; j < 59; j++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        for (int j = 0; j < 239; j++) cyc(1'b0, 1'b0);
        chk_time("h12_115959", 11, 59, 59, 0, 0, 0);
        cyc(1'b0, 1'b0);
        chk_time("h12_noon", 12, 0, 0, 0, 0, 1);
        // 12:59:59 rolls to 01:00:00 with pm unchanged.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        for (int j = 0; j < 59; j++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        for (int j = 0; j < 239; j++) cyc(1'b0, 1'b0);
        chk_time("h12_125959", 12, 59, 59, 0, 0, 1);
        cyc(1'b0, 1'b0);
        chk_time("h12_one", 1, 0, 0, 0, 0, 1);
`endif

        // Random button traffic against the model, with one async reset.
        for (int i = 0; i < 3000; i++) begin
            r_mb = ($urandom_range(0, 39) == 0);
            r_ab = ($urandom_range(0, 2) == 0);
            cyc(r_mb, r_ab);
            if (i == 1500) mid_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_time_keeper_ctrl
`default_nettype wire

// File: doc/time_keeper_ctrl.md
# time_keeper_ctrl

Synchronous controller for the time-of-day digit chain. It divides the system clock into a one-second tick, sequences carries across the seconds, minutes and hours BCD digits within a single clock domain, and runs a three-state set-mode FSM driven by two pre-debounced button pulses. It sits between the board button/debounce logic and the seven-segment display mux, and supplies all six BCD digits plus mode status.

## Interface
- TICK_DIV, 100_000_000, clk cycles per one-second tick (≥2; benches use small values)
- BLINK_DIV, 25_000_000, clk cycles per blink half-period (≥1)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- mode_btn  in  1  single-cycle pulse; advances FSM state
- adv_btn  in  1  single-cycle pulse; increments the field being set
- sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi  out  4 each  registered BCD digits
- mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN (3 never produced)
- blink  out  1  field-blink enable for the display
- pm  out  1  PM indicator (constant 0 unless TWELVE_HOUR_EN)

## Operation
- Reset values: 24 h build, all digits 0 (00:00:00). 12 h build, 12:00:00 with pm=0. Reset values for all builds: mode=RUN, blink=0, prescaler=0, blink counter=0.
- Prescaler: counts 0..TICK_DIV-1 in RUN only. tick=1 in the cycle count==TICK_DIV-1, then count wraps to 0. Prescaler is held at 0 in SET_HR and SET_MIN.
- RUN, on tick: sec_lo increments 0..9. Carry goes to sec_hi 0..5, then min_lo 0..9, min_hi 0..5, then hours. All carries resolve in the same edge.
- Hours, 24 h: 00..23. 23 goes to 00. hr_lo wraps at 9 normally, and at 3 when hr_hi=2.
- FSM transitions on mode_btn: RUN→SET_HR→SET_MIN→RUN.
- SET_HR: adv_btn increments hours with the same wrap rule. No carry or borrow into other fields. Seconds and minutes are frozen.
- SET_MIN: adv_btn increments minutes 00..59, wrapping to 00 with no carry into hours.
- Leaving SET_MIN for RUN clears seconds to 00.
- adv_btn is ignored in RUN. tick cannot occur outside RUN.
- Simultaneous events:
  - tick and mode_btn in the same RUN cycle: the tick is applied and the state becomes SET_HR.
  - adv_btn and mode_btn in the same set-state cycle: the increment is applied to the current field, then the state advances.
- blink:
  - In SET_HR and SET_MIN, blink toggles every BLINK_DIV cycles, starting at 1 on entry to each set state.
  - In RUN, blink=0 and the blink counter is held at 0.
- Reset mid-operation: all state returns to reset values asynchronously. No partial carry survives.

## Timing
- All outputs are registered. A change sampled at edge N is visible after edge N; there are no combinational paths from inputs to outputs.
- First tick after reset deassertion: TICK_DIV rising edges later.
- Button response: one edge after the pulse is sampled.
- Button pulses wider than one cycle are counted once per high cycle.

## Configuration
- TWELVE_HOUR_EN defined: hours run 01..12. 11:59:59 rolls to 12:00:00 and toggles pm. 12:59:59 rolls to 01:00:00 with pm unchanged. In SET_HR, adv_btn from 11 to 12 toggles pm, and adv_btn from 12 to 01 leaves pm unchanged.
- TWELVE_HOUR_EN undefined: 24 h behaviour as above, and pm is tied to 0.

## Structure
- Package clock_pkg holds:
  - the mode enum (RUN, SET_HR, SET_MIN)
  - digit limit constants: SEC_HI_MAX=5, MIN_HI_MAX=5, HR24_MAX=23, HR12_MIN=1, HR12_MAX=12
- Sub-module bcd_digit_counter: synchronous, with en, a max-value input, clear and carry_out. It is instantiated for sec_lo, sec_hi, min_lo and min_hi.
- Hours pair logic stays in the top, because its wrap depends on both digits.

## Test plan
- TICK_DIV=4, release reset, run 4 cycles → 00:00:01 visible after the 4th edge; 240 cycles → 00:01:00.
- Preload 23:59:59 via SET mode, return to RUN, one tick → 00:00:00 in one edge.
- mode_btn ×1, adv_btn ×5 → mode=1, hours 05, minutes and seconds unchanged. mode_btn → mode=2, blink=1 on entry.
- In SET_MIN at 59, adv_btn → minutes 00, hours unchanged. mode_btn → RUN with seconds 00.
- tick and mode_btn in the same cycle at 00:00:09 → 00:00:10 and mode=1. Assert reset mid-carry → all outputs at reset values before the next edge.
- TWELVE_HOUR_EN, 11:59:59 pm=0, tick → 12:00:00 pm=1. From 12:59:59, tick → 01:00:00 pm=1.
